serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_rx_pkg.sv | 16 +
 rtl/serial_rx_obuf.sv | 46 ++++
 rtl/serial_rx.sv | 116 +++++++++++
 tb/tb_serial_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and line-level constants for the serial receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  // An idle line sits high; a start bit or a break pulls it low.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_BREAK = 1'b0;

endpackage

// File: rtl/serial_rx_obuf.sv
// Output holding register: keeps a received word until the consumer takes
// it, and flags a good word that arrives while the held one is still unread.
module serial_rx_obuf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ovr
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ovr;

  // Load a new word when the slot is free or is being emptied this cycle;
  // otherwise keep the old word and pulse overrun for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (i_load) begin
        if (!r_valid || i_ready) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovr   = r_ovr;

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: one bit per clock, start bit, LSB-first data,
// optional even parity, stop bit. Bad frames are dropped with an error pulse.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              dready,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              perr,
  output logic              ferr,
  output logic              ovr
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              r_sinQ;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_mismatch;
  logic              r_perr;
  logic              r_ferr;
  logic              w_deliver;

  // Register the line once; the state machine only ever looks at this copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sinQ <= LINE_IDLE;
    end else begin
      r_sinQ <= sin;
    end
  end

  // A good frame is handed to the output buffer on the clean stop bit.
  assign w_deliver = (r_state == STOP) && (r_sinQ == LINE_IDLE) && !r_mismatch;

  // Frame state machine with registered parity/framing error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mismatch <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sinQ == LINE_BREAK) begin
            r_state    <= DATA;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
          end
        end
        DATA: begin
          r_shift[r_cnt] <= r_sinQ;
          if (r_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              r_state <= PARITY;
            end else begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          r_mismatch <= (^r_shift) ^ r_sinQ;
          r_state    <= STOP;
        end
        STOP: begin
          if (r_sinQ == LINE_IDLE) begin
            r_perr  <= r_mismatch;
            r_state <= IDLE;
          end else begin
            r_ferr  <= 1'b1;
            r_state <= BREAK;
          end
        end
        BREAK: begin
          if (r_sinQ == LINE_IDLE) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign perr = r_perr;
  assign ferr = r_ferr;

  serial_rx_obuf #(
    .DATA_W(DATA_W)
  ) u_obuf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_deliver),
    .i_data (r_shift),
    .i_ready(dready),
    .o_data (dout),
    .o_valid(dvalid),
    .o_ovr  (ovr)
  );

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: a vector table of single frames plus
// hand-built sequences for back-to-back overrun, break, mid-frame reset and
// the 5-bit no-parity configuration.
module tb_serial_rx;

  typedef struct {
    logic [7:0] data;
    logic       parBit;
    logic       stopBit;
    logic       ready;
    logic       expDvalid;
    logic       expHold;
    logic [7:0] expDout;
    logic       expPerr;
    logic       expFerr;
    logic       expOvr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       dready;
  logic [7:0] dout;
  logic       dvalid;
  logic       perr;
  logic       ferr;
  logic       ovr;

  logic       sin2;
  logic       dready2;
  logic [4:0] dout2;
  logic       dvalid2;
  logic       perr2;
  logic       ferr2;
  logic       ovr2;

  int assertCount = 0;
  int failCount   = 0;

  vec_t vecs[9];
  logic seqQ[$];
  logic [7:0] logDout[0:63];
  logic       logDv[0:63];
  logic       logPerr[0:63];
  logic       logFerr[0:63];
  logic       logOvr[0:63];
  int cntDv, cntPerr, cntFerr, cntOvr;

  serial_rx #(
    .DATA_W   (8),
    .PARITY_EN(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sin   (sin),
    .dready(dready),
    .dout  (dout),
    .dvalid(dvalid),
    .perr  (perr),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  serial_rx #(
    .DATA_W   (5),
    .PARITY_EN(0)
  ) dut5 (
    .clk   (clk),
    .rst   (rst),
    .sin   (sin2),
    .dready(dready2),
    .dout  (dout2),
    .dvalid(dvalid2),
    .perr  (perr2),
    .ferr  (ferr2),
    .ovr   (ovr2)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) seqQ.push_back(1'b1);
  endtask

  task automatic pushFrame(input logic [7:0] data, input logic par, input logic stop);
    seqQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) seqQ.push_back(data[i]);
    seqQ.push_back(par);
    seqQ.push_back(stop);
  endtask

  // Drive one queued bit per negedge; log index i holds the outputs seen
  // just before bit i is driven, so a stop bit at index k reports at k+2.
  task automatic runSeq();
    cntDv = 0; cntPerr = 0; cntFerr = 0; cntOvr = 0;
    for (int i = 0; i < seqQ.size(); i++) begin
      @(negedge clk);
      logDout[i] = dout;
      logDv[i]   = dvalid;
      logPerr[i] = perr;
      logFerr[i] = ferr;
      logOvr[i]  = ovr;
      cntDv   += int'(dvalid);
      cntPerr += int'(perr);
      cntFerr += int'(ferr);
      cntOvr  += int'(ovr);
      sin = seqQ[i];
    end
    sin = 1'b1;
    seqQ.delete();
  endtask

  // Send one table frame and check the cycles around its stop bit.
  task automatic applyStimulus(input vec_t v, input int idx);
    dready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sin = 1'b1;
    end
    dready = v.ready;
    pushFrame(v.data, v.parBit, v.stopBit);
    for (int i = 0; i < seqQ.size(); i++) begin
      @(negedge clk);
      sin = seqQ[i];
    end
    seqQ.delete();
    @(negedge clk);
    checkOutput($sformatf("vec%0d_flags_s1", idx), 16'({dvalid, perr, ferr, ovr}), 16'h0);
    sin = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_flags_s2", idx), 16'({dvalid, perr, ferr, ovr}),
                16'({v.expDvalid, v.expPerr, v.expFerr, v.expOvr}));
    if (v.expDvalid) checkOutput($sformatf("vec%0d_dout_s2", idx), 16'(dout), 16'(v.expDout));
    @(negedge clk);
    checkOutput($sformatf("vec%0d_flags_s3", idx), 16'({dvalid, perr, ferr, ovr}),
                16'({v.expHold, 3'b000}));
    if (v.expHold) checkOutput($sformatf("vec%0d_dout_s3", idx), 16'(dout), 16'(v.expDout));
  endtask

  initial begin
    logic [11:0] seq5;

    //            data   par   stop  rdy   dv    hold  dout   perr  ferr  ovr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; sin = 1'b0; dready = 1'b1; sin2 = 1'b1; dready2 = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", 16'({dvalid, perr, ferr, ovr}), 16'h0);
    checkOutput("reset_dout", 16'(dout), 16'h0);
    checkOutput("reset_dout5", 16'({dvalid2, dout2}), 16'h0);
    rst = 1'b0; sin = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Two back-to-back good frames with the consumer stalled.
    dready = 1'b1;
    repeat (3) @(negedge clk);
    dready = 1'b0;
    pushIdle(2); pushFrame(8'h11, 1'b0, 1'b1); pushFrame(8'h22, 1'b0, 1'b1); pushIdle(4);
    runSeq();
    checkOutput("ovr_first_dv", 16'(logDv[14]), 16'h1);
    checkOutput("ovr_first_dout", 16'(logDout[14]), 16'h11);
    checkOutput("ovr_before", 16'(logOvr[24]), 16'h0);
    checkOutput("ovr_pulse", 16'(logOvr[25]), 16'h1);
    checkOutput("ovr_kept_dout", 16'(logDout[25]), 16'h11);
    checkOutput("ovr_kept_dv", 16'(logDv[26]), 16'h1);
    checkOutput("ovr_count", 16'(cntOvr), 16'h1);
    checkOutput("ovr_other_err", 16'(cntPerr + cntFerr), 16'h0);
    dready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ovr_drained", 16'(dvalid), 16'h0);

    // Framing error followed by a long break; the low line must not restart.
    pushIdle(2); pushFrame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) seqQ.push_back(1'b0);
    pushIdle(6);
    runSeq();
    checkOutput("brk_ferr_s2", 16'(logFerr[14]), 16'h1);
    checkOutput("brk_ferr_count", 16'(cntFerr), 16'h1);
    checkOutput("brk_no_data", 16'(cntDv + cntPerr + cntOvr), 16'h0);

    // Abort a frame with a one-cycle reset after data bit 3, then resume.
    pushIdle(2); seqQ.push_back(1'b0);
    for (int i = 0; i < 4; i++) seqQ.push_back(1'b1);
    runSeq();
    checkOutput("rst_pre_pulses", 16'(cntDv + cntPerr + cntFerr + cntOvr), 16'h0);
    @(negedge clk);
    rst = 1'b1; sin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pushIdle(2); pushFrame(8'h5A, 1'b0, 1'b1); pushIdle(3);
    runSeq();
    checkOutput("rst_dv_s2", 16'(logDv[14]), 16'h1);
    checkOutput("rst_dout", 16'(logDout[14]), 16'h5A);
    checkOutput("rst_dv_count", 16'(cntDv), 16'h1);
    checkOutput("rst_err_count", 16'(cntPerr + cntFerr + cntOvr), 16'h0);

    // 5-bit, no-parity instance: frame 0x1F, stop bit at index 8.
    seq5 = 12'hFFB;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 9)  checkOutput("w5_dv_s1", 16'(dvalid2), 16'h0);
      if (i == 10) begin
        checkOutput("w5_dv_s2", 16'(dvalid2), 16'h1);
        checkOutput("w5_dout", 16'(dout2), 16'h1F);
        checkOutput("w5_err", 16'({perr2, ferr2, ovr2}), 16'h0);
      end
      if (i == 11) checkOutput("w5_dv_s3", 16'(dvalid2), 16'h0);
      sin2 = seq5[i];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
